// File: rtl/rv64_ctrl_pkg.sv
// Shared definitions for the RV64 multicycle controller: FSM state encoding,
// base opcodes and the select encodings driven onto the datapath muxes.
// Datapath width is 64 bits; nothing in the controller depends on it.
package rv64_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXR,
        S_EXI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_TRAP
    } state_t;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate generator format select
    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_FUNCTW = 2'b11;

endpackage

// File: rtl/rv64_branch_cond.sv
// Branch condition evaluation for the conditional branch group.
// Ports:
//   funct3     in  3  branch kind from the instruction
//   zero/lt/ltu in 1  ALU flags from the rs1-rs2 subtraction
//   taken      out 1  branch condition holds
//   bad_funct3 out 1  funct3 is not a defined branch (010/011)
module rv64_branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = zero;   // beq
            3'b001:  taken = ~zero;  // bne
            3'b100:  taken = lt;     // blt
            3'b101:  taken = ~lt;    // bge
            3'b110:  taken = ltu;    // bltu
            3'b111:  taken = ~ltu;   // bgeu
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv64_mc_controller.sv
// Multicycle control FSM for the RV64 core. Steps one instruction at a time
// through fetch, decode, execute, memory access and write-back, driving all
// datapath selects and write strobes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr[31:0]           IR contents
//   zero, lt, ltu         ALU compare flags
//   mem_ready             memory completes the current request
//   mem_req, mem_we       memory request / store qualifier
//   adr_src               memory address: 0 PC, 1 ALUOut
//   ir_write, pc_write, reg_write  datapath write strobes
//   alu_src_a/b, alu_op, result_src, imm_src  datapath selects
//   illegal               sticky illegal-instruction flag
module rv64_mc_controller
    import rv64_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    state_t     state_q, state_d;
    // Cleared asynchronously with the state; holds every output at 0 until
    // the first clock edge after reset release, so mem_req rises one cycle
    // after rst_n deasserts.
    logic       active_q;

    logic [6:0] opcode;
    logic       br_taken;
    logic       br_bad;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    // rd/rs fields and funct7 are consumed by the datapath, not here.
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    rv64_branch_cond u_branch_cond (
        .funct3     (instr[14:12]),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .taken      (br_taken),
        .bad_funct3 (br_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_NONE;
        illegal    = 1'b0;

        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALU;
                    // IR capture and PC+4 happen on the cycle the read completes.
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch/JAL target into ALUOut.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_OP, OP_OP32:    state_d = S_EXR;
                        OP_IMM, OP_IMM32:  state_d = S_EXI;
                        OP_BRANCH: begin
                            imm_src = IMM_B;
                            state_d = S_BRANCH;
                        end
                        OP_JAL: begin
                            imm_src = IMM_J;
                            state_d = S_JAL;
                        end
                        OP_JALR:           state_d = S_JALR1;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    if (opcode == OP_STORE) begin
                        imm_src = IMM_S;
                        state_d = S_MEMWR;
                    end else begin
                        imm_src = IMM_I;
                        state_d = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_RDATA;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = (opcode == OP_OP32) ? ALU_FUNCTW : ALU_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_EXI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    alu_op    = (opcode == OP_IMM32) ? ALU_FUNCTW : ALU_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_U;
                    alu_op    = ALU_ADD;
                    state_d   = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_U;
                    alu_op    = ALU_ADD;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALU_SUB;
                    result_src = RES_ALUOUT;
                    // ALUOut still holds the target computed in DECODE.
                    pc_write   = br_taken;
                    state_d    = br_bad ? S_TRAP : S_FETCH;
                end
                S_JAL: begin
                    // PC <- target from ALUOut while the ALU forms OldPC+4
                    // for the link write in ALUWB.
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                    state_d    = S_ALUWB;
                end
                S_JALR1: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    alu_op    = ALU_ADD;
                    state_d   = S_JALR2;
                end
                S_JALR2: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                    state_d    = S_ALUWB;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: state_d = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_rv64_mc_controller.sv
module tb_rv64_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_src;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    rv64_mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef enum {K_LOAD, K_STORE, K_R, K_RW, K_I, K_IW, K_BR, K_JAL, K_JALR,
                  K_LUI, K_AUIPC, K_BAD_OP, K_BAD_BR} kind_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return K_R;
            7'b0111011: return K_RW;
            7'b0010011: return K_I;
            7'b0011011: return K_IW;
            7'b1100011: return (ins[14:13] == 2'b01) ? K_BAD_BR : K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD_OP;
        endcase
    endfunction

    // fl = {zero, lt, ltu}
    function automatic bit branch_taken(input logic [2:0] f3, input logic [2:0] fl);
        case (f3)
            3'd0: return fl[2];
            3'd1: return !fl[2];
            3'd4: return fl[1];
            3'd5: return !fl[1];
            3'd6: return fl[0];
            3'd7: return !fl[0];
            default: return 1'b0;
        endcase
    endfunction

    // Asserts reset mid-cycle, checks all outputs are low, releases it and
    // checks the first fetch request. Returns aligned to a falling edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check({tag, "_rst_outs"}, {14'h0, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_rst_outs_hold"}, {14'h0, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rel_mem_req"}, {31'h0, mem_req}, 32'h1);
        check({tag, "_rel_adr_src"}, {31'h0, adr_src}, 32'h0);
        @(negedge clk);
    endtask

    // Runs one instruction starting at a falling edge in its FETCH cycle.
    // wf/wm are memory wait cycles for the fetch and data access.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [2:0] fl,
                             input int wf, input int wm);
        kind_e k;
        int exp_cyc, exp_rw, exp_pcx, exp_memd, exp_we;
        logic [2:0] exp_imm_dec, exp_imm_ex;
        logic [1:0] exp_op, exp_res;
        int cyc = 0, fcnt = 0, mcnt = 0, limit;
        int nrw = 0, npcx = 0, nir = 0, ir_cyc = -1, nmemd = 0, nwe = 0, nreq_after = 0;
        logic [2:0] imm_dec = 3'h7, imm_ex = 3'h7;
        logic [1:0] op_ex = 2'h0, res_wb = 2'h0;
        bit done = 0, seen_ill = 0, ill_drop = 0;

        k = classify(ins);
        case (k)
            K_LOAD:  exp_cyc = 5;
            K_BR:    exp_cyc = 3;
            K_JALR:  exp_cyc = 5;
            default: exp_cyc = 4;
        endcase
        exp_cyc += wf + (((k == K_LOAD) || (k == K_STORE)) ? wm : 0);
        exp_rw   = (k == K_STORE || k == K_BR) ? 0 : 1;
        exp_pcx  = (k == K_JAL || k == K_JALR) ? 1 :
                   (k == K_BR) ? int'(branch_taken(ins[14:12], fl)) : 0;
        exp_memd = (k == K_LOAD || k == K_STORE) ? wm + 1 : 0;
        exp_we   = (k == K_STORE) ? wm + 1 : 0;
        exp_imm_dec = (k == K_BR || k == K_BAD_BR) ? 3'b011 : (k == K_JAL) ? 3'b101 : 3'b000;
        case (k)
            K_LOAD, K_I, K_IW, K_JALR: exp_imm_ex = 3'b001;
            K_STORE:                   exp_imm_ex = 3'b010;
            K_LUI, K_AUIPC:            exp_imm_ex = 3'b100;
            default:                   exp_imm_ex = 3'b000;
        endcase
        case (k)
            K_R, K_I:   exp_op = 2'b10;
            K_RW, K_IW: exp_op = 2'b11;
            K_BR:       exp_op = 2'b01;
            default:    exp_op = 2'b00;
        endcase
        exp_res = (k == K_LOAD) ? 2'b01 : 2'b00;

        instr = ins;
        {zero, lt, ltu} = fl;
        limit = (k == K_BAD_OP || k == K_BAD_BR) ? wf + 12 : 60;
        while (!done && cyc < limit) begin
            if (fcnt > wf && mem_req && !adr_src) begin
                done = 1;
            end else begin
                if (mem_req && !adr_src) begin
                    mem_ready = (fcnt == wf);
                    fcnt++;
                end else if (mem_req) begin
                    mem_ready = (mcnt == wm);
                    mcnt++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                if (ir_write) begin nir++; ir_cyc = cyc; end
                if (pc_write && !ir_write) npcx++;
                if (reg_write) begin nrw++; res_wb = result_src; end
                if (mem_req && adr_src) nmemd++;
                if (mem_we) nwe++;
                if (mem_req && cyc > wf) nreq_after++;
                if (cyc == wf + 1) imm_dec = imm_src;
                if (cyc == wf + 2) begin imm_ex = imm_src; op_ex = alu_op; end
                if (illegal) seen_ill = 1;
                else if (seen_ill) ill_drop = 1;
                @(negedge clk);
                cyc++;
            end
        end

        check({tag, "_ir_write_cnt"}, nir, 1);
        check({tag, "_ir_write_cycle"}, ir_cyc, wf);
        check({tag, "_imm_decode"}, {29'h0, imm_dec}, {29'h0, exp_imm_dec});
        if (k == K_BAD_OP || k == K_BAD_BR) begin
            check({tag, "_illegal"}, {31'h0, illegal}, 32'h1);
            check({tag, "_illegal_sticky"}, {31'h0, ill_drop}, 32'h0);
            check({tag, "_no_req_in_trap"}, nreq_after, 0);
            check({tag, "_trap_no_pcwrite"}, npcx, 0);
        end else begin
            check({tag, "_cycles"}, cyc, exp_cyc);
            check({tag, "_reg_write_cnt"}, nrw, exp_rw);
            check({tag, "_pc_write_cnt"}, npcx, exp_pcx);
            check({tag, "_data_req_cycles"}, nmemd, exp_memd);
            check({tag, "_mem_we_cycles"}, nwe, exp_we);
            check({tag, "_imm_exec"}, {29'h0, imm_ex}, {29'h0, exp_imm_ex});
            check({tag, "_alu_op_exec"}, {30'h0, op_ex}, {30'h0, exp_op});
            if (exp_rw != 0) check({tag, "_result_src_wb"}, {30'h0, res_wb}, {30'h0, exp_res});
            check({tag, "_no_illegal"}, {31'h0, seen_ill}, 32'h0);
        end
    endtask

    logic [6:0] ops [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0111011,
                             7'b0010011, 7'b0011011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        logic [31:0] r;
        kind_e rk;
        int guard;

        #1;
        check("reset_outs", {14'h0, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal}, 32'h0);
        do_reset("init");

        run_instr("addi",   32'h00500093, 3'b000, 0, 0);
        run_instr("lw_w3",  32'h00002083, 3'b000, 0, 3);
        run_instr("beq_t",  32'h00208463, 3'b100, 0, 0);
        run_instr("beq_nt", 32'h00208463, 3'b000, 0, 0);
        run_instr("bgeu_t", 32'h0020F463, 3'b010, 0, 0);
        run_instr("jal",    32'h008000EF, 3'b000, 0, 0);
        run_instr("jalr",   32'h000080E7, 3'b000, 0, 0);
        run_instr("sw_w2",  32'h00102023, 3'b000, 1, 2);
        run_instr("add",    32'h002081B3, 3'b000, 0, 0);
        run_instr("addw",   32'h002081BB, 3'b000, 2, 0);
        run_instr("addiw",  32'h0010809B, 3'b000, 0, 0);
        run_instr("lui",    32'h000010B7, 3'b000, 0, 0);
        run_instr("auipc",  32'h00001097, 3'b000, 0, 0);

        // Reset while a load waits in its data read with mem_ready low.
        instr = 32'h00002083;
        guard = 0;
        while (!(mem_req && adr_src) && guard < 20) begin
            mem_ready = mem_req && !adr_src;
            @(negedge clk);
            guard++;
        end
        mem_ready = 1'b0;
        check("memrd_reached", {31'h0, mem_req && adr_src}, 32'h1);
        @(negedge clk);
        do_reset("mid_memrd");

        run_instr("trap_op", 32'h0000007F, 3'b000, 0, 0);
        do_reset("after_trap_op");
        run_instr("trap_br", 32'h0020A463, 3'b100, 1, 0);
        do_reset("after_trap_br");

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 11)];
            rk = classify(r);
            run_instr($sformatf("rand%0d", i), r, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
            if (rk == K_BAD_OP || rk == K_BAD_BR) do_reset($sformatf("rand%0d_rst", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv64_mc_controller.md
# rv64_mc_controller

Multicycle control FSM for the RV64 core. Sequences one instruction at a time through the shared datapath (memory port, IR, register file, ALU, immediate generator): fetch, decode, execute, memory access and write-back. Drives every datapath select and write strobe, including the 3-bit immediate-format select consumed by the immediate generator. It sits between the instruction register and the datapath muxes.

## Interface
- XLEN, 64, datapath width (informational; controller logic is width-independent)
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- zero / lt / ltu  in  1 each  ALU flags for the current rs1-rs2 subtraction
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a store
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  write rd
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 subtract (compare), 10 funct-decoded, 11 funct-decoded 32-bit W
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- imm_src  out  3  001 I, 010 S, 011 B, 100 U, 101 J, 000 none
- illegal  out  1  sticky illegal-opcode flag

## Operation
- Moore outputs decoded from state; imm_src in DECODE is also a function of the opcode.
- States and transitions:
  - FETCH: mem_req, adr_src=0, a=PC, b=4, add, result_src=10. Wait while !mem_ready. When mem_ready, pulse ir_write and pc_write, then go to DECODE.
  - DECODE: a=OldPC, b=imm, add, so ALUOut = branch/JAL target. imm_src = B for branch, J for jal, else 000. Next state by opcode:
    - load 0000011 / store 0100011 → MEMADR
    - 0110011 / 0111011 → EXR
    - 0010011 / 0011011 → EXI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR1
    - 0110111 → LUI
    - 0010111 → AUIPC
    - else → TRAP
  - MEMADR: a=rs1, b=imm, add. imm_src=I for a load, S for a store. Next: MEMRD for a load, MEMWR for a store.
  - MEMRD: mem_req, adr_src=1; wait for mem_ready, then go to MEMWB.
  - MEMWB: reg_write, result_src=01, then FETCH.
  - MEMWR: mem_req, mem_we, adr_src=1; wait for mem_ready, then FETCH.
  - EXR: a=rs1, b=rs2, alu_op=10 (or 11 for opcode 0111011), then ALUWB.
  - EXI: a=rs1, b=imm, imm_src=I, alu_op=10 (or 11 for opcode 0011011), then ALUWB.
  - LUI: a=zero, b=imm, imm_src=U, add, then ALUWB.
  - AUIPC: a=OldPC, b=imm, imm_src=U, add, then ALUWB.
  - ALUWB: reg_write, result_src=00, then FETCH.
  - BRANCH: a=rs1, b=rs2, alu_op=01, result_src=00. pc_write = taken(funct3, flags), then FETCH.
    - beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu.
    - funct3 010/011 → TRAP.
  - JAL: a=OldPC, b=4, add, result_src=00, pc_write, then ALUWB.
    - ALUOut now holds OldPC+4, which ALUWB writes to rd.
  - JALR1: a=rs1, b=imm, imm_src=I, add, then JALR2.
  - JALR2: a=OldPC, b=4, add, result_src=00, pc_write, then ALUWB. The datapath clears bit 0 of the target.
  - TRAP: illegal=1. Stays in TRAP, all strobes 0, until reset.
- Unlisted outputs are 0 in each state.

## Timing
- Reset:
  - Asynchronous to FETCH, at any point mid-instruction; an in-flight memory request is abandoned.
  - While rst_n=0, every output is 0, including mem_req and illegal. A flop cleared asynchronously gates the outputs.
  - mem_req first rises in the first cycle after rst_n deasserts.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5.
- Each memory wait cycle adds one cycle.
- Handshake:
  - mem_req, mem_we and adr_src stay stable until the cycle in which mem_ready is sampled high.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- ir_write and pc_write in FETCH are single-cycle, coincident with mem_ready.
- At most one pc_write per instruction.

## Structure
- Package rv64_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - imm_src encodings (001–101)
  - alu_src_a, alu_src_b, result_src and alu_op encodings
- Sub-module rv64_branch_cond: combinational; inputs funct3, zero, lt, ltu; outputs taken and bad_funct3.
- Main FSM: one state register plus a combinational output/next-state block.

## Test plan
- Reset mid-MEMRD with mem_ready held low:
  - all outputs 0 during reset;
  - mem_req=1 with adr_src=0 on the first cycle after release.
- addi x1,x0,5 (0x00500093), zero-wait memory:
  - states FETCH, DECODE, EXI, ALUWB;
  - imm_src=001 in EXI; reg_write for exactly one cycle; 4 cycles total.
- lw with mem_ready delayed 3 cycles in MEMRD:
  - mem_req held for 4 cycles, then MEMWB with result_src=01;
  - 8 cycles total.
- beq (0x00208463):
  - with zero=1: pc_write in BRANCH and imm_src=011 in DECODE;
  - with zero=0: no pc_write;
  - bgeu with ltu=0: taken.
- jal (0x008000EF) and jalr (0x000080E7):
  - imm_src=101 in DECODE (jal) and 001 in JALR1 (jalr);
  - pc_write exactly once; reg_write in ALUWB;
  - 4 and 5 cycles respectively.
- Opcode 0x7F, and branch with funct3=010:
  - enters TRAP with illegal=1 held;
  - no further mem_req until reset.
